// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID reader: FSM state type, Avalon word
// addresses and the default expected ID/timestamp values.
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID_REQ  = 3'd1,
    ST_ID_WAIT = 3'd2,
    ST_TS_REQ  = 3'd3,
    ST_TS_WAIT = 3'd4,
    ST_FINISH  = 3'd5
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_EXP_ID_DEFAULT = 32'd0;
  localparam logic [31:0] SYSID_EXP_TS_DEFAULT = 32'd1581777168;

  function automatic logic sysid_is_ts_state(input sysid_state_e st);
    return (st == ST_TS_REQ) || (st == ST_TS_WAIT);
  endfunction

endpackage

// File: rtl/sysid_reader.sv
// Avalon-MM read master: reads sysid word 0 (ID) and word 1 (timestamp),
// compares them and latches pass/timeout. SYSID_READER_AUTOSTART_EN adds a boot-time start.
module sysid_reader
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXP_ID      = SYSID_EXP_ID_DEFAULT,
  parameter logic [31:0] EXP_TS      = SYSID_EXP_TS_DEFAULT,
  parameter bit          CHECK_TS    = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  sysid_state_e state_q, state_d;
  logic        read_q, read_d;
  logic        address_q, address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic [7:0]  cnt_q, cnt_d;

  logic start_go;
  logic in_req;
  logic in_wait;
  logic is_ts;
  logic resp;

`ifdef SYSID_READER_AUTOSTART_EN
  // Set by reset, consumed by the first IDLE cycle afterwards.
  logic auto_q, auto_d;

  always_comb begin
    auto_d   = auto_q && (state_q != ST_IDLE);
    start_go = start || auto_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) auto_q <= 1'b1;
    else          auto_q <= auto_d;
  end
`else
  always_comb start_go = start;
`endif

  always_comb begin
    in_req  = (state_q == ST_ID_REQ)  || (state_q == ST_TS_REQ);
    in_wait = (state_q == ST_ID_WAIT) || (state_q == ST_TS_WAIT);
    is_ts   = sysid_is_ts_state(state_q);
    // A response in the accept cycle counts as a zero-latency reply.
    resp    = (in_req && !waitrequest && readdatavalid) || (in_wait && readdatavalid);
  end

  always_comb begin
    state_d   = state_q;
    read_d    = read_q;
    address_d = address_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    id_d      = id_q;
    ts_d      = ts_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_go) begin
          state_d   = ST_ID_REQ;
          read_d    = 1'b1;
          address_d = SYSID_ADDR_ID;
          busy_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
        end
      end

      ST_ID_REQ, ST_ID_WAIT, ST_TS_REQ, ST_TS_WAIT: begin
        if (resp) begin
          if (is_ts) begin
            ts_d    = readdata;
            state_d = ST_FINISH;
            read_d  = 1'b0;
          end else begin
            id_d      = readdata;
            state_d   = ST_TS_REQ;
            read_d    = 1'b1;
            address_d = SYSID_ADDR_TS;
            cnt_d     = '0;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d   = ST_FINISH;
          read_d    = 1'b0;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (in_req && !waitrequest) begin
            state_d = is_ts ? ST_TS_WAIT : ST_ID_WAIT;
            read_d  = 1'b0;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (id_q == EXP_ID) && (!CHECK_TS || (ts_q == EXP_TS)) && !timeout_q;
      end

      default: begin
        state_d = ST_IDLE;
        read_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      read_q    <= 1'b0;
      address_q <= SYSID_ADDR_ID;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      id_q      <= '0;
      ts_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      read_q    <= read_d;
      address_q <= address_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      id_q      <= id_d;
      ts_q      <= ts_d;
      cnt_q     <= cnt_d;
    end
  end

  assign read     = read_q;
  assign address  = address_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign timeout  = timeout_q;
  assign id_value = id_q;
  assign ts_value = ts_q;

endmodule

// File: tb/tb_sysid_reader.sv
// Bench for sysid_reader: three instances (default, CHECK_TS=0, TIMEOUT_CYC=8),
// each with its own Avalon slave model, checked every cycle against a schedule model.
module tb_sysid_reader;
  import sysid_pkg::*;

  localparam int N   = 3;
  localparam int INF = 32'h7fffffff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start;
  logic        rd    [N];
  logic        addr  [N];
  logic        wr    [N];
  logic        rdv   [N];
  logic [31:0] rdata [N];
  logic        busy  [N];
  logic        done  [N];
  logic        pass  [N];
  logic        tmo   [N];
  logic [31:0] idv   [N];
  logic [31:0] tsv   [N];

  sysid_reader u_dut0 (
    .clock(clk), .reset_n(reset_n), .start(start), .address(addr[0]), .read(rd[0]),
    .waitrequest(wr[0]), .readdata(rdata[0]), .readdatavalid(rdv[0]), .busy(busy[0]),
    .done(done[0]), .pass(pass[0]), .timeout(tmo[0]), .id_value(idv[0]), .ts_value(tsv[0])
  );

  sysid_reader #(.CHECK_TS(1'b0)) u_dut1 (
    .clock(clk), .reset_n(reset_n), .start(start), .address(addr[1]), .read(rd[1]),
    .waitrequest(wr[1]), .readdata(rdata[1]), .readdatavalid(rdv[1]), .busy(busy[1]),
    .done(done[1]), .pass(pass[1]), .timeout(tmo[1]), .id_value(idv[1]), .ts_value(tsv[1])
  );

  sysid_reader #(.TIMEOUT_CYC(8)) u_dut2 (
    .clock(clk), .reset_n(reset_n), .start(start), .address(addr[2]), .read(rd[2]),
    .waitrequest(wr[2]), .readdata(rdata[2]), .readdatavalid(rdv[2]), .busy(busy[2]),
    .done(done[2]), .pass(pass[2]), .timeout(tmo[2]), .id_value(idv[2]), .ts_value(tsv[2])
  );

  function automatic int tmo_of(input int i);
    return (i == 2) ? 8 : 255;
  endfunction

  function automatic bit chk_ts_of(input int i);
    return (i != 1);
  endfunction

  // ---------------- Avalon slave models ----------------
  int          cfg_wait_id = 0;
  int          cfg_wait_ts = 0;
  int          cfg_lat     = 1;
  bit          cfg_never_ts = 1'b0;
  logic [31:0] cfg_id = SYSID_EXP_ID_DEFAULT;
  logic [31:0] cfg_ts = SYSID_EXP_TS_DEFAULT;

  int          wcnt    [N];
  int          pend    [N];
  int          acc_cnt [N];
  logic [31:0] pdata   [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      wr[i]    = rd[i] && (wcnt[i] < (addr[i] ? cfg_wait_ts : cfg_wait_id));
      rdv[i]   = (pend[i] == 1) ||
                 ((cfg_lat == 0) && rd[i] && !wr[i] && !(cfg_never_ts && addr[i]));
      rdata[i] = (pend[i] == 1) ? pdata[i] : (addr[i] ? cfg_ts : cfg_id);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rd[i] && wr[i]) wcnt[i] <= wcnt[i] + 1;
      else                wcnt[i] <= 0;
      if (rd[i] && !wr[i]) begin
        acc_cnt[i] <= acc_cnt[i] + 1;
        if (cfg_lat > 0 && !(cfg_never_ts && addr[i])) begin
          pend[i]  <= cfg_lat;
          pdata[i] <= addr[i] ? cfg_ts : cfg_id;
        end else if (pend[i] > 0) begin
          pend[i] <= pend[i] - 1;
        end
      end else if (pend[i] > 0) begin
        pend[i] <= pend[i] - 1;
      end
    end
  end

  // ---------------- schedule model ----------------
  typedef struct packed {
    logic        read;
    logic        address;
    logic        busy;
    logic        done;
    logic        pass;
    logic        to;
    logic [31:0] id;
    logic [31:0] ts;
  } exp_t;

  typedef struct {
    bit          valid;
    int          kill;
    int          s, id_last, id_resp, b, ts_last, ts_resp, f;
    bit          to_new, pass_new, pass_old, to_old;
    logic [31:0] id_old, id_new, ts_old, ts_new;
  } plan_t;

  plan_t pl [N];
  int    cyc = 0;
  bit    chk_en = 1'b0;
  int    checks = 0;
  int    failures = 0;
  int    done_cnt  [N];
  int    last_done [N];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t expect_at(input plan_t p, input int c);
    exp_t e;
    e = '0;
    if (!p.valid || c >= p.kill) return e;
    e.read    = (c >= p.s && c <= p.id_last) || (p.b >= 0 && c >= p.b && c <= p.ts_last);
    e.address = (p.b >= 0) && (c >= p.b);
    e.busy    = (c >= p.s) && (c <= p.f);
    e.done    = (c == p.f + 1);
    e.pass    = (c < p.s) ? p.pass_old : ((c <= p.f) ? 1'b0 : p.pass_new);
    e.to      = (c < p.s) ? p.to_old : ((c < p.f) ? 1'b0 : p.to_new);
    e.id      = (p.id_resp >= 0 && c > p.id_resp) ? p.id_new : p.id_old;
    e.ts      = (p.ts_resp >= 0 && c > p.ts_resp) ? p.ts_new : p.ts_old;
    return e;
  endfunction

  // One read: request from cycle a; reply W+L cycles later unless it exceeds T cycles.
  function automatic void txn(input int a, input int w, input int l, input bit never,
                              input int t, output int last_read, output int resp,
                              output int endc);
    if (!never && (w + l + 1 <= t)) begin
      last_read = a + w;
      resp      = a + w + l;
      endc      = resp;
    end else begin
      endc      = a + t - 1;
      resp      = -1;
      last_read = (a + w < endc) ? a + w : endc;
    end
  endfunction

  function automatic plan_t make_plan(input int i, input int s);
    plan_t p;
    exp_t  o;
    int    e1, e2;
    logic [31:0] idf, tsf;
    o = expect_at(pl[i], s - 1);
    p.valid = 1'b1;  p.kill = INF;  p.s = s;
    p.pass_old = o.pass;  p.to_old = o.to;  p.id_old = o.id;  p.ts_old = o.ts;
    p.id_new = cfg_id;  p.ts_new = cfg_ts;
    p.b = -1;  p.ts_last = -1;  p.ts_resp = -1;  p.to_new = 1'b0;
    txn(s, cfg_wait_id, cfg_lat, 1'b0, tmo_of(i), p.id_last, p.id_resp, e1);
    if (p.id_resp < 0) begin
      p.to_new = 1'b1;
      p.f = e1 + 1;
    end else begin
      p.b = e1 + 1;
      txn(p.b, cfg_wait_ts, cfg_lat, cfg_never_ts, tmo_of(i), p.ts_last, p.ts_resp, e2);
      p.f = e2 + 1;
      if (p.ts_resp < 0) p.to_new = 1'b1;
    end
    idf = (p.id_resp >= 0) ? p.id_new : p.id_old;
    tsf = (p.ts_resp >= 0) ? p.ts_new : p.ts_old;
    p.pass_new = !p.to_new && (idf == SYSID_EXP_ID_DEFAULT) &&
                 (!chk_ts_of(i) || (tsf == SYSID_EXP_TS_DEFAULT));
    return p;
  endfunction

  function automatic void chk(input string name, input int i, input logic [31:0] got,
                              input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", name, i, cyc, got, exp);
    end
  endfunction

  exp_t ce;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        ce = expect_at(pl[i], cyc);
        chk("read", i, 32'(rd[i]), 32'(ce.read));
        if (ce.read) chk("address", i, 32'(addr[i]), 32'(ce.address));
        chk("busy", i, 32'(busy[i]), 32'(ce.busy));
        chk("done", i, 32'(done[i]), 32'(ce.done));
        chk("pass", i, 32'(pass[i]), 32'(ce.pass));
        chk("timeout", i, 32'(tmo[i]), 32'(ce.to));
        chk("id_value", i, idv[i], ce.id);
        chk("ts_value", i, tsv[i], ce.ts);
        if (done[i] === 1'b1) begin
          done_cnt[i]++;
          last_done[i] = cyc;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
`ifdef SYSID_READER_AUTOSTART_EN
    for (int i = 0; i < N; i++) pl[i] = make_plan(i, cyc + 1);
`endif
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) pl[i].kill = cyc + 1;
  endtask

  task automatic wait_idle();
    int target;
    target = cyc;
    for (int i = 0; i < N; i++)
      if (pl[i].valid && pl[i].kill == INF && pl[i].f + 2 > target) target = pl[i].f + 2;
    if (target - cyc > 1000) begin
      failures++;
      $display("FAIL wait_idle budget cyc=%0d target=%0d", cyc, target);
    end else begin
      while (cyc < target) tick(1);
    end
  endtask

  task automatic run_check(output int s);
    start = 1'b1;
    s = cyc + 1;
    for (int i = 0; i < N; i++) pl[i] = make_plan(i, s);
    tick(1);
    start = 1'b0;
  endtask

  int s, acc0, dn0, guard;

  initial begin
    for (int i = 0; i < N; i++) begin
      pl[i].valid = 1'b0;
      pl[i].kill  = INF;
      done_cnt[i] = 0;
      last_done[i] = 0;
    end
    reset_n = 1'b0;
    start   = 1'b0;
    tick(3);
    chk_en = 1'b1;

    // Boot: autostart runs exactly one check, otherwise nothing is read.
    release_reset();
    tick(100);
    wait_idle();
`ifdef SYSID_READER_AUTOSTART_EN
    chk("boot_done_cnt", 0, 32'(done_cnt[0]), 32'd1);
    chk("boot_pass", 0, 32'(pass[0]), 32'd1);
`else
    chk("boot_done_cnt", 0, 32'(done_cnt[0]), 32'd0);
    chk("boot_reads", 0, 32'(acc_cnt[0]), 32'd0);
`endif

    // Nominal check, 1-cycle latency; extra starts while busy and in FINISH.
    acc0 = acc_cnt[0];
    dn0  = done_cnt[0];
    run_check(s);
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    guard = 0;
    while (cyc < pl[0].f && guard < 50) begin
      tick(1);
      guard++;
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle();
    tick(3);
    chk("t1_done_cycle", 0, 32'(last_done[0] - s), 32'd5);
    chk("t1_done_cnt", 0, 32'(done_cnt[0] - dn0), 32'd1);
    chk("t1_reads", 0, 32'(acc_cnt[0] - acc0), 32'd2);
    chk("t1_pass", 0, 32'(pass[0]), 32'd1);
    chk("t1_timeout", 0, 32'(tmo[0]), 32'd0);
    chk("t1_id", 0, idv[0], 32'd0);
    chk("t1_ts", 0, tsv[0], 32'd1581777168);

    // Zero-wait, zero-latency slave.
    cfg_lat = 0;
    run_check(s);
    wait_idle();
    chk("t2_done_cycle", 0, 32'(last_done[0] - s), 32'd3);
    chk("t2_pass", 0, 32'(pass[0]), 32'd1);

    // Wrong timestamp: fails only where the timestamp is checked.
    cfg_lat = 1;
    cfg_ts  = 32'h12345678;
    run_check(s);
    wait_idle();
    chk("t3_pass_chk", 0, 32'(pass[0]), 32'd0);
    chk("t3_pass_nochk", 1, 32'(pass[1]), 32'd1);
    chk("t3_ts", 1, tsv[1], 32'h12345678);

    // 10 waitrequest cycles on the ID read.
    cfg_ts      = SYSID_EXP_TS_DEFAULT;
    cfg_wait_id = 10;
    acc0 = acc_cnt[0];
    run_check(s);
    wait_idle();
    cfg_wait_id = 0;
    chk("t4_reads", 0, 32'(acc_cnt[0] - acc0), 32'd2);
    chk("t4_pass", 0, 32'(pass[0]), 32'd1);
    chk("t4_timeout_short", 2, 32'(tmo[2]), 32'd1);

    // Timestamp read never answered.
    cfg_never_ts = 1'b1;
    run_check(s);
    wait_idle();
    cfg_never_ts = 1'b0;
    chk("t5_done_cycle", 2, 32'(last_done[2] - s), 32'd11);
    chk("t5_timeout", 2, 32'(tmo[2]), 32'd1);
    chk("t5_pass", 2, 32'(pass[2]), 32'd0);
    chk("t5_ts_kept", 2, tsv[2], 32'h12345678);
    chk("t5_timeout_long", 0, 32'(tmo[0]), 32'd1);

    // Reset during ID_WAIT; the slave's late reply must be ignored.
    cfg_lat = 3;
    run_check(s);
    tick(1);
    assert_reset();
    tick(1);
    chk("t6_read", 0, 32'(rd[0]), 32'd0);
    chk("t6_busy", 0, 32'(busy[0]), 32'd0);
    chk("t6_id", 0, idv[0], 32'd0);
`ifdef SYSID_READER_AUTOSTART_EN
    tick(2);
`endif
    cfg_lat = 1;
    release_reset();
    tick(4);
    wait_idle();
    run_check(s);
    wait_idle();
    chk("t6_rerun_pass", 0, 32'(pass[0]), 32'd1);
    chk("t6_rerun_id", 0, idv[0], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
